// File: rtl/phy_crc_pkg.sv
// Shared definitions for the CRC32 engine scheduler: FSM encoding, CRC constants
// and requester indices.
package phy_crc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NIB_LO,
    NIB_HI,
    FLUSH,
    CAPTURE,
    GAP
  } state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;

  // Edges from the final nibble strobe to the last strobe the engine expects.
  localparam int FLUSH_DLY = 5;

endpackage

// File: rtl/phy_crc_rr_arb.sv
// Two-way round-robin arbiter. While lock is high no grant is offered;
// advance moves priority away from the requester that was just served.
module phy_crc_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       advance,
  input  logic       served,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic prio;  // 0 favours TX on a tie

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (advance) begin
      prio <= ~served;
    end
  end

  always_comb begin
    gnt_valid = !lock && (|req);
    if (req == 2'b11) begin
      gnt_idx = prio;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/phy_crc_sched.sv
// Byte sequencer and arbiter in front of the shared nibble-serial CRC32 engine.
// Optional stall abort is built when PHY_CRC_SCHED_TIMEOUT_EN is defined.
module phy_crc_sched
  import phy_crc_pkg::*;
#(
  parameter int NIB_CYC     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_byte,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  done,
  output logic [31:0] crc_val,
  output logic        crc_fail,
  output logic        busy,
  output logic        owner,
  output logic [3:0]  crc_data_in,
  output logic        crc_data_en,
  output logic        crc_data_last,
  input  logic [31:0] crc_out,
  input  logic        crc_out_fail
);

  if (NIB_CYC < 4 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("phy_crc_sched: NIB_CYC must be >= 4 and TIMEOUT_CYC >= 1");
  end

  localparam int            CW     = $clog2(NIB_CYC + FLUSH_DLY + 2);
  localparam logic [CW-1:0] LO_END = CW'(NIB_CYC - 1);
  localparam logic [CW-1:0] HI_END = CW'(NIB_CYC - 2);
  localparam logic [CW-1:0] FL_END = CW'(FLUSH_DLY);

  // Handshake: a byte moves when req_valid[i] and req_ready[i] are both high at
  // a rising edge; ready is only ever offered to the owner while in LOAD.
  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    byte_q;
  logic          last_q;
  logic [3:0]    nib_q;
  logic          gnt_valid;
  logic          gnt_idx;
  logic [7:0]    cur_byte;
  logic          cur_last;
  logic          accept;

  assign cur_byte = (owner == REQ_RX) ? req_byte[15:8] : req_byte[7:0];
  assign cur_last = req_last[owner];
  assign accept   = (state == LOAD) && req_valid[owner];

  always_comb begin
    req_ready = '0;
    if (state == LOAD) req_ready[owner] = 1'b1;
  end

  phy_crc_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .lock      (state != IDLE),
    .advance   (state == GAP),
    .served    (owner),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

`ifdef PHY_CRC_SCHED_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] stall_cnt;
  logic          abort;
  logic          timeout;
  assign timeout = (state == LOAD) && !req_valid[owner] && (stall_cnt == TO_END);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      byte_q        <= '0;
      last_q        <= 1'b0;
      nib_q         <= '0;
      done          <= '0;
      crc_val       <= '0;
      crc_fail      <= 1'b0;
      busy          <= 1'b0;
      owner         <= 1'b0;
      crc_data_in   <= '0;
      crc_data_en   <= 1'b0;
      crc_data_last <= 1'b0;
`ifdef PHY_CRC_SCHED_TIMEOUT_EN
      stall_cnt     <= '0;
      abort         <= 1'b0;
`endif
    end else begin
      crc_data_en   <= 1'b0;
      crc_data_last <= 1'b0;
      done          <= '0;
      // Data trails its strobe by one edge and then holds until the next nibble.
      if (crc_data_en && !crc_data_last) crc_data_in <= nib_q;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_idx;
            busy  <= 1'b1;
            state <= LOAD;
`ifdef PHY_CRC_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
            abort     <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (accept) begin
            byte_q <= cur_byte;
            last_q <= cur_last;
            cnt    <= '0;
            state  <= NIB_LO;
`ifdef PHY_CRC_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
          end else if (timeout) begin
            abort <= 1'b1;
            cnt   <= CW'(1);
            state <= FLUSH;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
`endif
          end
        end
        NIB_LO: begin
          if (cnt == '0) begin
            crc_data_en <= 1'b1;
            nib_q       <= byte_q[3:0];
          end
          if (cnt == LO_END) begin
            cnt   <= '0;
            state <= NIB_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NIB_HI: begin
          if (cnt == '0) begin
            crc_data_en <= 1'b1;
            nib_q       <= byte_q[7:4];
          end
          // Leaving one edge early lets the next low nibble land exactly 2*NIB_CYC later.
          if (cnt == '0 && last_q) begin
            cnt   <= CW'(1);
            state <= FLUSH;
          end else if (cnt == HI_END) begin
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == FL_END) begin
            crc_data_en   <= 1'b1;
            crc_data_last <= 1'b1;
            cnt           <= '0;
            state         <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == '0) begin
            cnt <= CW'(1);
          end else begin
            crc_val     <= crc_out;
`ifdef PHY_CRC_SCHED_TIMEOUT_EN
            crc_fail    <= crc_out_fail | abort;
`else
            crc_fail    <= crc_out_fail;
`endif
            done[owner] <= 1'b1;
            state       <= GAP;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_crc_sched.sv
// Bench for phy_crc_sched: nibble-serial CRC32 engine model, byte-level CRC
// reference, directed scenarios followed by randomized messages.
module tb_phy_crc_sched;
  import phy_crc_pkg::*;

  localparam int W = 34;  // {port, fail, crc}
  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_byte = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [1:0]  done;
  logic [31:0] crc_val;
  logic        crc_fail;
  logic        busy;
  logic        owner;
  logic [3:0]  crc_data_in;
  logic        crc_data_en;
  logic        crc_data_last;
  logic [31:0] crc_out;
  logic        crc_out_fail;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  int nib_exp_q[$];
  int cyc = 0;
  int en_cnt = 0;
  int nib_seen = 0;
  int last_nib_cyc = 0;
  int rdy_viol = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  phy_crc_sched #(.NIB_CYC(4), .TIMEOUT_CYC(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_byte      (req_byte),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .done          (done),
    .crc_val       (crc_val),
    .crc_fail      (crc_fail),
    .busy          (busy),
    .owner         (owner),
    .crc_data_in   (crc_data_in),
    .crc_data_en   (crc_data_en),
    .crc_data_last (crc_data_last),
    .crc_out       (crc_out),
    .crc_out_fail  (crc_out_fail)
  );

  // ---------------- reference functions ----------------
  function automatic logic [31:0] crc32_bytes(input bq_t m);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (m[i]) begin
      c ^= {24'h0, m[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // A message carrying its own CRC (LSB first) leaves the final CRC at ~residue.
  function automatic logic [W-1:0] model(input int p, input bq_t m);
    logic [31:0] c = crc32_bytes(m);
    return {p[0], (c != 32'h2144DF1C), c};
  endfunction

  function automatic logic [31:0] eng_nib(input logic [31:0] s, input logic [3:0] n);
    logic [31:0] c = s;
    for (int k = 0; k < 4; k++) c = (c[0] ^ n[k]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- engine model (consumes data one edge after its strobe) ----------------
  logic [31:0] eng_st;
  logic        eng_pend;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_st = CRC_INIT;
      eng_pend = 1'b0;
      crc_out = '0;
      crc_out_fail = 1'b0;
    end else begin
      if (eng_pend) begin
        eng_st = eng_nib(eng_st, crc_data_in);
        eng_pend = 1'b0;
      end
      if (crc_data_en && crc_data_last) begin
        crc_out = ~eng_st;
        crc_out_fail = (eng_st != 32'hDEBB20E3);  // reflected form of CRC_RESIDUE
        eng_st = CRC_INIT;
      end else if (crc_data_en) begin
        eng_pend = 1'b1;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      nib_seen = 0;
    end else begin
      cyc++;
      if (crc_data_last) check("last_has_en", crc_data_en, 1'b1);
      if (crc_data_en && !crc_data_last) begin
        en_cnt++;
        nib_seen++;
        last_nib_cyc = cyc;
      end
      if (crc_data_en && crc_data_last) begin
        check("en_to_last_gap", cyc - last_nib_cyc, 5);
        if (nib_exp_q.size() > 0) check("nibbles_per_msg", nib_seen, nib_exp_q.pop_front());
        nib_seen = 0;
      end
      if (busy && owner == REQ_TX && req_ready[1]) rdy_viol++;
      if (busy && owner == REQ_RX && req_ready[0]) rdy_viol++;
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", done, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("done_port", done, e[33] ? 2'b10 : 2'b01);
          check("crc_val", crc_val, e[31:0]);
          check("crc_fail", crc_fail, e[32]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_byte(input int p, input logic [7:0] b, input logic l);
    int t = 0;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_byte[p*8 +: 8] = b;
    req_last[p] = l;
    while (!req_ready[p] && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("ready_timeout", req_ready[p], 1'b1);
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    req_last[p] = 1'b0;
  endtask

  task automatic send_msg(input int p, input bq_t m, input int stall_at, input int stall_len);
    int e0;
    for (int i = 0; i < m.size(); i++) begin
      if (i == stall_at) begin
        repeat (10) @(negedge clk);
        e0 = en_cnt;
        repeat (stall_len - 10) @(negedge clk);
        check("stall_no_en", en_cnt, e0);
      end
      drive_byte(p, m[i], i == m.size() - 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("done_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {req_ready, done, crc_val, crc_fail, busy, owner,
                            crc_data_in, crc_data_en, crc_data_last}, 45'h0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bq_t s9, s13, sf, s1, part, m;
    logic [31:0] c;
    int p, len;

    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    s13 = s9;
    s13.push_back(8'h26); s13.push_back(8'h39); s13.push_back(8'hF4); s13.push_back(8'hCB);

    do_reset();

    // TX "123456789"
    exp_q.push_back({1'b0, 1'b1, 32'hCBF43926}); nib_exp_q.push_back(18);
    send_msg(0, s9, -1, 0);
    wait_done();

    // RX with CRC appended: residue matches
    exp_q.push_back({1'b1, 1'b0, 32'h2144DF1C}); nib_exp_q.push_back(26);
    send_msg(1, s13, -1, 0);
    wait_done();

    // RX with one payload bit flipped
    sf = s13;
    sf[2] = sf[2] ^ 8'h04;
    exp_q.push_back(model(1, sf)); nib_exp_q.push_back(26);
    send_msg(1, sf, -1, 0);
    wait_done();
    check("flip_fail_flag", crc_fail, 1'b1);

    // single zero byte
    s1 = '{8'h00};
    exp_q.push_back({1'b0, 1'b1, 32'hD202EF8D}); nib_exp_q.push_back(2);
    send_msg(0, s1, -1, 0);
    wait_done();

`ifdef PHY_CRC_SCHED_TIMEOUT_EN
    // stall beyond TIMEOUT_CYC: aborted message, forced fail
    part = '{8'h31, 8'h32, 8'h33, 8'h34};
    exp_q.push_back({1'b0, 1'b1, crc32_bytes(part)}); nib_exp_q.push_back(8);
    foreach (part[i]) drive_byte(0, part[i], 1'b0);
    wait_done();
    check("abort_fail_flag", crc_fail, 1'b1);
`else
    // 20-cycle stall mid-message: same CRC as the unstalled run
    exp_q.push_back({1'b0, 1'b1, 32'hCBF43926}); nib_exp_q.push_back(18);
    send_msg(0, s9, 4, 20);
    wait_done();
`endif

    // reset after 3 bytes, then resend the full message
    for (int i = 0; i < 3; i++) drive_byte(0, s9[i], 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", {req_ready, done, crc_val, crc_fail, busy, owner,
                                  crc_data_in, crc_data_en, crc_data_last}, 45'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 32'hCBF43926}); nib_exp_q.push_back(18);
    send_msg(0, s9, -1, 0);
    wait_done();

    // both requesters valid in the same cycle straight from reset: TX first
    do_reset();
    exp_q.push_back({1'b0, 1'b1, 32'hCBF43926}); nib_exp_q.push_back(18);
    exp_q.push_back({1'b1, 1'b0, 32'h2144DF1C}); nib_exp_q.push_back(26);
    fork
      send_msg(0, s9, -1, 0);
      send_msg(1, s13, -1, 0);
    join
    wait_done();

    // randomized messages
    for (int n = 0; n < 10; n++) begin
      p = $urandom_range(0, 1);
      len = $urandom_range(1, 6);
      m = {};
      for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        c = crc32_bytes(m);
        m.push_back(c[7:0]); m.push_back(c[15:8]); m.push_back(c[23:16]); m.push_back(c[31:24]);
      end
      exp_q.push_back(model(p, m)); nib_exp_q.push_back(2 * m.size());
      send_msg(p, m, -1, 0);
      wait_done();
    end

    check("ready_lock_violations", rdy_viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
